p2_mem_read: RTL and testbench
==============================

P2_MEM_READ -- requirements
Module: p2_mem_read

Interface
REQ-001 SHALL have parameter DATA_W, default 16; width of one pooling-2 feature value.
REQ-002 SHALL have parameter NUM_PASSES, default 10; full 16-entry sweeps per run, one per FC output neuron, range 1..16.
REQ-003 SHALL have port clk, input, 1; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1; one-cycle request to begin a run; honoured only in IDLE or DONE.
REQ-006 SHALL have port addr0, output, 4; read address into the pooling-2 output memory (4x4 map).
REQ-007 SHALL have port rd_en, output, 1; memory read strobe.
REQ-008 SHALL have port q0, input, DATA_W; memory read data, valid the cycle after rd_en.
REQ-009 SHALL have port data_out, output, DATA_W; value presented downstream.
REQ-010 SHALL have port data_valid, output, 1; data_out valid.
REQ-011 SHALL have port data_ready, input, 1; downstream accepts; a transfer occurs when data_valid and data_ready are both high.
REQ-012 SHALL have port pass_idx, output, 4; pass number of the entry on data_out.
REQ-013 SHALL have port last, output, 1; high with data_valid when the entry on data_out is address 15 of its pass.
REQ-014 SHALL have port done, output, 1; run complete.

Function
REQ-015 SHALL implement states IDLE, READ, DRAIN, DONE; IDLE->READ on start; READ->DRAIN after address 15 of pass NUM_PASSES-1 is issued; DRAIN->DONE when buffer empty and no read outstanding; DONE->READ on start.
REQ-016 SHALL issue reads only in READ: rd_en high when (buffer occupancy + outstanding reads) < 2 at that cycle.
REQ-017 SHALL begin each run at addr0=0, pass 0; addr0 increments by 1 per issued read; 15 wraps to 0 and advances the issue-side pass counter.
REQ-018 SHALL capture q0 into a 2-entry FIFO at the edge ending the cycle after each rd_en; the FIFO carries each entry's pass number and last flag.
REQ-019 SHALL drive data_out/pass_idx/last from the FIFO head; data_valid = FIFO non-empty.
REQ-020 SHALL keep data_out, pass_idx and last stable while data_valid is high and data_ready is low.
REQ-021 SHALL assert data_valid first in the third cycle after the start cycle (start in cycle T, rd_en in cycle T+1, data_valid in cycle T+3).
REQ-022 SHALL sustain one transfer per cycle with data_ready held high; the run then delivers 16*NUM_PASSES entries.
REQ-023 SHALL permit a FIFO capture and a FIFO transfer in the same cycle without data loss or duplication.
REQ-024 SHALL hold done high in DONE, asserted the cycle after the final transfer; cleared the cycle after start is accepted.
REQ-025 SHALL ignore start in READ and DRAIN.
REQ-026 SHALL never let addr0 exceed 15 or pass_idx exceed NUM_PASSES-1.

Reset
REQ-027 SHALL on reset enter IDLE, flush the FIFO, and discard any outstanding read (q0 of the following cycle not captured).
REQ-028 SHALL on reset drive addr0=0, rd_en=0, data_out=0, data_valid=0, pass_idx=0, last=0, done=0.
REQ-029 SHALL give reset priority over start and over every other event in the same cycle, including mid-run.

Configuration
REQ-030 SHALL, when macro P2_READ_RELU_EN is defined, present data_out as 0 for any entry whose stored value is negative (two's complement MSB=1); all other values unchanged.
REQ-031 SHALL, without P2_READ_RELU_EN, present stored values unmodified; timing is identical either way.

Verification
REQ-032 SHALL verify: memory preloaded mem[i]=i+1, NUM_PASSES=1, data_ready=1, start pulse -> data_valid from cycle T+3, values 1..16 on consecutive cycles, last high with 16 only, done high the next cycle.
REQ-033 SHALL verify: NUM_PASSES=2, data_ready toggling 1,0,1,0 -> 32 transfers, pass_idx 0 for the first 16 and 1 for the next 16, values stable while stalled, no loss or duplicates.
REQ-034 SHALL verify: data_ready=0 for 20 cycles after start -> rd_en pulsed exactly twice, addr0 held at 2, data_out=1 stable.
REQ-035 SHALL verify: reset asserted at the 7th transfer -> next cycle all outputs 0, IDLE; a later start restarts at addr0=0 with value 1.
REQ-036 SHALL verify: start pulsed mid-run -> ignored, sequence unchanged; start in DONE -> done clears, new run from address 0.
REQ-037 SHALL verify: with P2_READ_RELU_EN, mem[3]=16'hFFF0 -> 4th output 0; without it -> 16'hFFF0.

Source files
------------

// File: rtl/p2_mem_read.sv
// Streams the 4x4 pooling-2 map NUM_PASSES times through a 2-entry skid FIFO with valid/ready.
// Optional macro P2_READ_RELU_EN clamps negative stored values to zero on the way into the FIFO.
module p2_mem_read #(
   parameter int DATA_W     = 16,
   parameter int NUM_PASSES = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [3:0]        addr0,
   output logic              rd_en,
   input  logic [DATA_W-1:0] q0,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic [3:0]        pass_idx,
   output logic              last,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [3:0] LAST_PASS = 4'(NUM_PASSES - 1);

   state_t            state_q, state_d;
   logic [3:0]        addr_q, addr_d;
   logic [3:0]        ipass_q, ipass_d;
   logic              out_q, out_d;
   logic [3:0]        out_pass_q, out_pass_d;
   logic              out_last_q, out_last_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              rptr_q, rptr_d;
   logic              wptr_q, wptr_d;
   logic [DATA_W-1:0] ent_data_q [2];
   logic [DATA_W-1:0] ent_data_d [2];
   logic [3:0]        ent_pass_q [2];
   logic [3:0]        ent_pass_d [2];
   logic              ent_last_q [2];
   logic              ent_last_d [2];

   logic              xfer;
   logic              push;
   logic              start_ok;
   logic              issue_last;
   logic [2:0]        load;
   logic [DATA_W-1:0] wdata;

   assign data_valid = (cnt_q != 2'd0);
   assign xfer       = data_valid && data_ready;
   assign push       = out_q;
   assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
   assign issue_last = (addr_q == 4'd15) && (ipass_q == LAST_PASS);
   // Occupancy is taken net of this cycle's transfer so a full-rate stream never bubbles.
   assign load       = {1'b0, cnt_q} + {2'b00, out_q} - {2'b00, xfer};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = READ;
         READ:    if (rd_en && issue_last) state_d = DRAIN;
         DRAIN:   if (!out_q && (cnt_d == 2'd0)) state_d = DONE;
         DONE:    if (start) state_d = READ;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_en = (state_q == READ) && (load < 3'd2);
      done  = (state_q == DONE);
   end

   always_comb begin
      wdata = q0;
`ifdef P2_READ_RELU_EN
      if (q0[DATA_W-1]) wdata = '0;
`endif
   end

   always_comb begin
      addr_d     = addr_q;
      ipass_d    = ipass_q;
      out_d      = rd_en;
      out_pass_d = ipass_q;
      out_last_d = (addr_q == 4'd15);
      if (start_ok) begin
         addr_d  = 4'd0;
         ipass_d = 4'd0;
      end else if (rd_en) begin
         addr_d = addr_q + 4'd1;
         if (addr_q == 4'd15) begin
            ipass_d = (ipass_q == LAST_PASS) ? 4'd0 : ipass_q + 4'd1;
         end
      end
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, xfer};
      rptr_d = rptr_q ^ xfer;
      wptr_d = wptr_q ^ push;
      for (int i = 0; i < 2; i++) begin
         ent_data_d[i] = ent_data_q[i];
         ent_pass_d[i] = ent_pass_q[i];
         ent_last_d[i] = ent_last_q[i];
         if (push && (wptr_q == 1'(i))) begin
            ent_data_d[i] = wdata;
            ent_pass_d[i] = out_pass_q;
            ent_last_d[i] = out_last_q;
         end
      end
   end

   // Clearing out_q on reset drops any read in flight, so the next q0 is never captured.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= 4'd0;
         ipass_q    <= 4'd0;
         out_q      <= 1'b0;
         out_pass_q <= 4'd0;
         out_last_q <= 1'b0;
         cnt_q      <= 2'd0;
         rptr_q     <= 1'b0;
         wptr_q     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            ent_data_q[i] <= '0;
            ent_pass_q[i] <= 4'd0;
            ent_last_q[i] <= 1'b0;
         end
      end else begin
         addr_q     <= addr_d;
         ipass_q    <= ipass_d;
         out_q      <= out_d;
         out_pass_q <= out_pass_d;
         out_last_q <= out_last_d;
         cnt_q      <= cnt_d;
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         for (int i = 0; i < 2; i++) begin
            ent_data_q[i] <= ent_data_d[i];
            ent_pass_q[i] <= ent_pass_d[i];
            ent_last_q[i] <= ent_last_d[i];
         end
      end
   end

   assign addr0    = addr_q;
   assign data_out = data_valid ? ent_data_q[rptr_q] : '0;
   assign pass_idx = data_valid ? ent_pass_q[rptr_q] : 4'd0;
   assign last     = data_valid && ent_last_q[rptr_q];

endmodule

// File: tb/tb_p2_mem_read.sv
// Directed bench for p2_mem_read: one instance with NUM_PASSES=1, one with NUM_PASSES=2.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_p2_mem_read;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset1, start1, ready1, rd1, valid1, last1, done1;
   logic [3:0]  addr1, pass1;
   logic [15:0] q1, dout1;
   logic        reset2, start2, ready2, rd2, valid2, last2, done2;
   logic [3:0]  addr2, pass2;
   logic [15:0] q2, dout2;
   logic [15:0] mem1 [16];
   logic [15:0] mem2 [16];

   int errors = 0;
   int checks = 0;

   p2_mem_read #(.DATA_W(16), .NUM_PASSES(1)) dut1 (
      .clk(clk), .reset(reset1), .start(start1), .addr0(addr1), .rd_en(rd1),
      .q0(q1), .data_out(dout1), .data_valid(valid1), .data_ready(ready1),
      .pass_idx(pass1), .last(last1), .done(done1));

   p2_mem_read #(.DATA_W(16), .NUM_PASSES(2)) dut2 (
      .clk(clk), .reset(reset2), .start(start2), .addr0(addr2), .rd_en(rd2),
      .q0(q2), .data_out(dout2), .data_valid(valid2), .data_ready(ready2),
      .pass_idx(pass2), .last(last2), .done(done2));

   initial begin
      q1 = '0;
      q2 = '0;
   end
   always @(posedge clk) begin
      if (rd1) q1 <= mem1[addr1];
      if (rd2) q2 <= mem2[addr2];
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset1 = 1'b1; reset2 = 1'b1;
      start1 = 1'b0; start2 = 1'b0;
      ready1 = 1'b1; ready2 = 1'b1;
      repeat (3) next_cycle();
      reset1 = 1'b0; reset2 = 1'b0;
      @(negedge clk);
      checks++;
      if ({addr1, rd1, dout1, valid1, pass1, last1, done1} !== 28'd0) begin
         errors++;
         $display("FAIL reset_dut1: outputs=%h required 0",
                  {addr1, rd1, dout1, valid1, pass1, last1, done1});
      end
      checks++;
      if ({addr2, rd2, dout2, valid2, pass2, last2, done2} !== 28'd0) begin
         errors++;
         $display("FAIL reset_dut2: outputs=%h required 0",
                  {addr2, rd2, dout2, valid2, pass2, last2, done2});
      end
      $display("reset released");
   endtask

   task automatic test_basic;
      logic exp_valid;
      for (int i = 0; i < 16; i++) mem1[i] = 16'(i + 1);
      ready1 = 1'b1;
      next_cycle(); start1 = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 20; k++) begin
         next_cycle(); start1 = 1'b0;
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (rd1 !== 1'b1 || addr1 !== 4'd0) begin
               errors++;
               $display("FAIL basic_first_read: rd_en=%b addr0=%0d required 1/0", rd1, addr1);
            end
         end
         exp_valid = (k >= 3) && (k <= 18);
         checks++;
         if (valid1 !== exp_valid) begin
            errors++;
            $display("FAIL basic_valid cycle T+%0d: data_valid=%b required %b", k, valid1, exp_valid);
         end
         if (exp_valid) begin
            $display("basic xfer data=%0d last=%b", dout1, last1);
            checks++;
            if (dout1 !== 16'(k - 2)) begin
               errors++;
               $display("FAIL basic_data cycle T+%0d: data_out=%0d required %0d", k, dout1, k - 2);
            end
            checks++;
            if (last1 !== (k == 18)) begin
               errors++;
               $display("FAIL basic_last cycle T+%0d: last=%b required %b", k, last1, k == 18);
            end
         end
         checks++;
         if (done1 !== (k >= 19)) begin
            errors++;
            $display("FAIL basic_done cycle T+%0d: done=%b required %b", k, done1, k >= 19);
         end
      end
   endtask

   task automatic test_relu_and_restart;
      logic [15:0] exp4;
`ifdef P2_READ_RELU_EN
      exp4 = 16'h0000;
`else
      exp4 = 16'hFFF0;
`endif
      mem1[3] = 16'hFFF0;
      next_cycle(); start1 = 1'b1;
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1) begin
         errors++;
         $display("FAIL restart_done_held: done=%b required 1", done1);
      end
      for (int k = 1; k <= 19; k++) begin
         next_cycle(); start1 = 1'b0;
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (done1 !== 1'b0) begin
               errors++;
               $display("FAIL restart_from_done: done=%b required 0", done1);
            end
            checks++;
            if (rd1 !== 1'b1) begin
               errors++;
               $display("FAIL restart_from_done: rd_en=%b required 1", rd1);
            end
            checks++;
            if (addr1 !== 4'd0) begin
               errors++;
               $display("FAIL restart_from_done: addr0=%0d required 0", addr1);
            end
         end
         if (k == 6) begin
            $display("relu xfer data=%h", dout1);
            checks++;
            if (valid1 !== 1'b1 || dout1 !== exp4) begin
               errors++;
               $display("FAIL relu_4th: valid=%b data_out=%h required 1/%h", valid1, dout1, exp4);
            end
         end
         if (k == 19) begin
            checks++;
            if (done1 !== 1'b1) begin
               errors++;
               $display("FAIL relu_run_done: done=%b required 1", done1);
            end
         end
      end
      mem1[3] = 16'd4;
   endtask

   task automatic test_stall;
      int rd_count = 0;
      int n = 1;
      ready1 = 1'b0;
      next_cycle(); start1 = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 20; k++) begin
         next_cycle(); start1 = 1'b0;
         @(negedge clk);
         if (rd1) rd_count++;
         if (k >= 3) begin
            checks++;
            if (valid1 !== 1'b1 || dout1 !== 16'd1) begin
               errors++;
               $display("FAIL stall_hold cycle T+%0d: valid=%b data_out=%0d required 1/1",
                        k, valid1, dout1);
            end
         end
      end
      checks++;
      if (rd_count != 2) begin
         errors++;
         $display("FAIL stall_rd_count: pulses=%0d required 2", rd_count);
      end
      checks++;
      if (addr1 !== 4'd2) begin
         errors++;
         $display("FAIL stall_addr: addr0=%0d required 2", addr1);
      end
      for (int c = 0; c < 60 && !done1; c++) begin
         next_cycle(); ready1 = 1'b1;
         @(negedge clk);
         if (valid1) begin
            $display("stall xfer data=%0d", dout1);
            checks++;
            if (dout1 !== 16'(n)) begin
               errors++;
               $display("FAIL stall_seq: data_out=%0d required %0d", dout1, n);
            end
            n++;
         end
      end
      checks++;
      if (n != 17 || done1 !== 1'b1) begin
         errors++;
         $display("FAIL stall_drain: transfers=%0d done=%b required 16/1", n - 1, done1);
      end
   endtask

   task automatic test_reset_mid;
      int seen = 0;
      ready1 = 1'b1;
      next_cycle(); start1 = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 30 && seen == 0; c++) begin
         next_cycle(); start1 = 1'b0;
         @(negedge clk);
         if (valid1 && dout1 === 16'd7) seen = 1;
      end
      checks++;
      if (seen == 0) begin
         errors++;
         $display("FAIL resetmid_no_7th: seventh entry never seen, required 1");
      end
      reset1 = 1'b1;
      next_cycle(); reset1 = 1'b0;
      @(negedge clk);
      checks++;
      if ({addr1, rd1, dout1, valid1, pass1, last1, done1} !== 28'd0) begin
         errors++;
         $display("FAIL resetmid_outputs: outputs=%h required 0",
                  {addr1, rd1, dout1, valid1, pass1, last1, done1});
      end
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         @(negedge clk);
         checks++;
         if (valid1 !== 1'b0 || rd1 !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_idle: valid=%b rd_en=%b required 0/0", valid1, rd1);
         end
      end
      next_cycle(); start1 = 1'b1;
      @(negedge clk);
      next_cycle(); start1 = 1'b0;
      @(negedge clk);
      checks++;
      if (rd1 !== 1'b1 || addr1 !== 4'd0) begin
         errors++;
         $display("FAIL resetmid_restart: rd_en=%b addr0=%0d required 1/0", rd1, addr1);
      end
      next_cycle(); @(negedge clk);
      next_cycle(); @(negedge clk);
      checks++;
      if (valid1 !== 1'b1 || dout1 !== 16'd1) begin
         errors++;
         $display("FAIL resetmid_first: valid=%b data_out=%0d required 1/1", valid1, dout1);
      end
      for (int c = 0; c < 40 && !done1; c++) begin
         next_cycle(); @(negedge clk);
      end
      checks++;
      if (done1 !== 1'b1) begin
         errors++;
         $display("FAIL resetmid_done: done=%b required 1", done1);
      end
   endtask

   task automatic test_start_mid;
      int n = 1;
      ready1 = 1'b1;
      next_cycle(); start1 = 1'b1;
      @(negedge clk);
      for (int c = 1; c < 60 && !(done1 && c > 2); c++) begin
         next_cycle(); start1 = (c == 8);
         @(negedge clk);
         if (valid1) begin
            $display("startmid xfer data=%0d last=%b", dout1, last1);
            checks++;
            if (dout1 !== 16'(n) || last1 !== (n == 16)) begin
               errors++;
               $display("FAIL startmid_seq: data_out=%0d last=%b required %0d/%b",
                        dout1, last1, n, n == 16);
            end
            n++;
         end
      end
      start1 = 1'b0;
      checks++;
      if (n != 17 || done1 !== 1'b1) begin
         errors++;
         $display("FAIL startmid_count: transfers=%0d done=%b required 16/1", n - 1, done1);
      end
   endtask

   task automatic test_two_pass;
      int n = 0;
      logic stalled = 1'b0;
      logic [20:0] held = '0;
      for (int i = 0; i < 16; i++) mem2[i] = 16'(i * 7 + 3);
      next_cycle(); start2 = 1'b1; ready2 = 1'b1;
      @(negedge clk);
      for (int c = 1; c < 300 && !done2; c++) begin
         next_cycle(); start2 = 1'b0; ready2 = (c % 2 == 0);
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (valid2 !== 1'b1 || {dout2, pass2, last2} !== held) begin
               errors++;
               $display("FAIL twopass_stable: valid=%b entry=%h required 1/%h",
                        valid2, {dout2, pass2, last2}, held);
            end
         end
         stalled = valid2 && !ready2;
         held = {dout2, pass2, last2};
         if (valid2 && ready2) begin
            $display("twopass xfer %0d data=%0d pass=%0d last=%b", n, dout2, pass2, last2);
            checks++;
            if (dout2 !== mem2[n % 16] || pass2 !== 4'(n / 16) || last2 !== (n % 16 == 15)) begin
               errors++;
               $display("FAIL twopass_entry %0d: data=%0d pass=%0d last=%b required %0d/%0d/%b",
                        n, dout2, pass2, last2, mem2[n % 16], n / 16, n % 16 == 15);
            end
            n++;
         end
      end
      checks++;
      if (n != 32 || done2 !== 1'b1) begin
         errors++;
         $display("FAIL twopass_count: transfers=%0d done=%b required 32/1", n, done2);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem1[i] = 16'(i + 1);
         mem2[i] = 16'(i + 1);
      end
      test_reset();
      test_basic();
      test_relu_and_restart();
      test_stall();
      test_reset_mid();
      test_start_mid();
      test_two_pass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
